// File: rtl/schoolbook_div.sv
// Restoring shift-subtract divider: 2N-bit dividend / N-bit divisor -> N-bit quotient and remainder.
// Latency N+2 cycles from accept to done (2 cycles for divide-by-zero or quotient overflow).
// start is only sampled in IDLE; requests while busy are dropped, not queued.
module schoolbook_div #(
    parameter int N = 256
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [2*N-1:0] a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [N-1:0]   q,
    output logic [N-1:0]   r,
    output logic           div_zero,
    output logic           ovf
);

    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {IDLE, CHECK, RUN, DONE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [N-1:0]  rem;     // partial remainder, seeded with the dividend's upper half
    logic [N-1:0]  lo;      // dividend lower half, consumed MSB first
    logic [N-1:0]  dvs;     // captured divisor
    logic [CW-1:0] cnt;     // RUN step index 0..N-1
    logic [N:0]    t;
    logic [N:0]    diff;
    logic          ge;
    logic [N-1:0]  rem_nxt;
    logic          last;

    // One restoring step: R < b holds on entry, so T < 2b and N+1 bits suffice.
    always_comb begin
        t       = {rem, lo[N-1]};
        diff    = t - {1'b0, dvs};
        ge      = (t >= {1'b0, dvs});
        rem_nxt = ge ? diff[N-1:0] : t[N-1:0];
        last    = (cnt == CW'(N - 1));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs decoded from the current state.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                busy = 1'b1;
                if (dvs == '0 || rem >= dvs) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: capture on accept, flag errors in CHECK, shift one quotient bit per RUN cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem      <= '0;
            lo       <= '0;
            dvs      <= '0;
            cnt      <= '0;
            q        <= '0;
            r        <= '0;
            div_zero <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        rem      <= a[2*N-1:N];
                        lo       <= a[N-1:0];
                        dvs      <= b;
                        q        <= '0;
                        r        <= '0;
                        div_zero <= 1'b0;
                        ovf      <= 1'b0;
                    end
                end
                CHECK: begin
                    cnt <= '0;
                    if (dvs == '0) begin
                        div_zero <= 1'b1;
                    end else if (rem >= dvs) begin
                        ovf <= 1'b1;
                    end
                end
                RUN: begin
                    rem <= rem_nxt;
                    lo  <= {lo[N-2:0], 1'b0};
                    q   <= {q[N-2:0], ge};
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        r <= rem_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_schoolbook_div.sv
// Directed and randomized checks of schoolbook_div at N=256.
// Latency, error paths, handshake spacing, mid-run reset and result arithmetic.
// Inputs are driven on the falling edge; outputs are sampled on the falling edge.
module tb_schoolbook_div;

    localparam int N = 256;
    typedef logic [2*N-1:0] w_t;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [2*N-1:0] a;
    logic [N-1:0]   b;
    logic           busy;
    logic           done;
    logic [N-1:0]   q;
    logic [N-1:0]   r;
    logic           div_zero;
    logic           ovf;

    int n_tests = 0;
    int n_fail  = 0;

    schoolbook_div #(.N(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .q        (q),
        .r        (r),
        .div_zero (div_zero),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input w_t obs, input w_t exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Launch one division and wait (bounded) for done; lat counts falling edges after the accept edge.
    task automatic run(input w_t av, input logic [N-1:0] bv, input bit pulse, output int lat);
        @(negedge clk);
        a     = av;
        b     = bv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 2*N) begin
            if (pulse && lat == 3) begin
                a     = ~av;
                b     = bv + 1'b1;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check("done_seen", w_t'(done), w_t'(1));
    endtask

    task automatic expect_result(input string tag, input w_t eq, input w_t er,
                                 input bit edz, input bit eovf);
        check({tag, "_q"},   w_t'(q),        eq);
        check({tag, "_r"},   w_t'(r),        er);
        check({tag, "_dz"},  w_t'(div_zero), w_t'(edz));
        check({tag, "_ovf"}, w_t'(ovf),      w_t'(eovf));
    endtask

    function automatic logic [N-1:0] rand_word();
        logic [N-1:0] v;
        for (int i = 0; i < N / 32; i++) begin
            v[i*32 +: 32] = $urandom;
        end
        return v;
    endfunction

    initial begin
        int lat;
        int acc [4];
        int n_acc;
        int n_done;
        logic prev_busy;
        logic [N-1:0] rb;
        logic [N-1:0] rh;
        w_t ra;
        w_t full_a;

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", w_t'(busy),     w_t'(0));
        check("rst_done", w_t'(done),     w_t'(0));
        check("rst_q",    w_t'(q),        w_t'(0));
        check("rst_r",    w_t'(r),        w_t'(0));
        check("rst_dz",   w_t'(div_zero), w_t'(0));
        check("rst_ovf",  w_t'(ovf),      w_t'(0));
        rst_n = 1'b1;

        // 15 / 5 with a start pulse (different operands) injected while busy.
        run(w_t'(15), N'(5), 1'b1, lat);
        check("small_lat", w_t'(lat), w_t'(258));
        check("small_busy_at_done", w_t'(busy), w_t'(1));
        expect_result("small", w_t'(3), w_t'(0), 1'b0, 1'b0);
        @(negedge clk);
        check("small_done_pulse", w_t'(done), w_t'(0));
        check("small_busy_fall",  w_t'(busy), w_t'(0));
        check("small_q_hold",     w_t'(q),    w_t'(3));

        // 2^512 - 2^256 - 1 divided by 2^256 - 1.
        full_a = {{(N-1){1'b1}}, 1'b0, {N{1'b1}}};
        run(full_a, {N{1'b1}}, 1'b0, lat);
        expect_result("full", w_t'({N{1'b1}}), w_t'({{(N-1){1'b1}}, 1'b0}), 1'b0, 1'b0);

        // Upper half = b - 1, lower half all ones: q = 2^256 - 1, r = b - 1.
        run({1'b0, {(N-1){1'b1}}, {N{1'b1}}}, {1'b1, {(N-1){1'b0}}}, 1'b0, lat);
        expect_result("edge", w_t'({N{1'b1}}), w_t'({1'b0, {(N-1){1'b1}}}), 1'b0, 1'b0);

        run(w_t'(1000), N'(7), 1'b0, lat);
        expect_result("d1000_7", w_t'(142), w_t'(6), 1'b0, 1'b0);

        // 2^256 / 3 = 0x5555...5 remainder 1.
        run(w_t'(1) << N, N'(3), 1'b0, lat);
        expect_result("p256_3", w_t'({(N/4){4'h5}}), w_t'(1), 1'b0, 1'b0);

        run(w_t'(5) << N, N'(5), 1'b0, lat);
        check("ovf_lat", w_t'(lat), w_t'(2));
        expect_result("ovf", w_t'(0), w_t'(0), 1'b0, 1'b1);

        run(w_t'(7) << N, N'(7), 1'b0, lat);
        expect_result("ovf_eq", w_t'(0), w_t'(0), 1'b0, 1'b1);

        run(w_t'(12345), N'(0), 1'b0, lat);
        check("dz_lat", w_t'(lat), w_t'(2));
        expect_result("dz", w_t'(0), w_t'(0), 1'b1, 1'b0);

        // start held high: accepts are N+3 cycles apart.
        @(negedge clk);
        a         = w_t'(15);
        b         = N'(5);
        start     = 1'b1;
        n_acc     = 0;
        prev_busy = busy;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (busy && !prev_busy && n_acc < 4) begin
                acc[n_acc] = i;
                n_acc++;
            end
            prev_busy = busy;
        end
        start = 1'b0;
        check("hold_n_acc", w_t'(n_acc), w_t'(3));
        check("hold_acc0",  w_t'(acc[0]), w_t'(0));
        check("hold_acc1",  w_t'(acc[1]), w_t'(259));
        check("hold_acc2",  w_t'(acc[2]), w_t'(518));
        lat = 0;
        while (!done && lat < 2*N) begin
            @(negedge clk);
            lat++;
        end
        check("hold_done_seen", w_t'(done), w_t'(1));
        expect_result("hold", w_t'(3), w_t'(0), 1'b0, 1'b0);

        // Reset about 100 steps into a run whose quotient bits are all ones.
        @(negedge clk);
        a     = full_a;
        b     = {N{1'b1}};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (101) @(negedge clk);
        check("mid_q_nonzero", w_t'(q != '0), w_t'(1));
        rst_n = 1'b0;
        @(negedge clk);
        check("mrst_busy", w_t'(busy), w_t'(0));
        check("mrst_done", w_t'(done), w_t'(0));
        check("mrst_q",    w_t'(q),    w_t'(0));
        check("mrst_r",    w_t'(r),    w_t'(0));
        rst_n  = 1'b1;
        n_done = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("mrst_no_done", w_t'(n_done), w_t'(0));
        run(w_t'(1000), N'(7), 1'b0, lat);
        expect_result("after_rst", w_t'(142), w_t'(6), 1'b0, 1'b0);

        // Random operands with the upper dividend half below the divisor.
        for (int k = 0; k < 40; k++) begin
            rb = rand_word() >> $urandom_range(0, N - 1);
            if (rb == '0) rb = N'(1);
            rh = rand_word() % rb;
            ra = {rh, rand_word()};
            run(ra, rb, 1'b0, lat);
            check("rand_q", w_t'(q), ra / {{N{1'b0}}, rb});
            check("rand_r", w_t'(r), ra % {{N{1'b0}}, rb});
            check("rand_identity", {{N{1'b0}}, q} * {{N{1'b0}}, rb} + {{N{1'b0}}, r}, ra);
            check("rand_r_lt_b", w_t'(r < rb), w_t'(1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
